multdiv_arbiter: RTL and testbench

MULTDIV_ARBITER -- requirements
Module: multdiv_arbiter

---
 rtl/multdiv_arb_pkg.sv | 17 +
 rtl/multdiv_arbiter_rr_arb2.sv | 19 +
 rtl/multdiv_arbiter.sv | 159 +++++++++++++++
 tb/tb_multdiv_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_arb_pkg.sv
// Shared types and constants for the two-requester multiply/divide arbiter.
package multdiv_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int TIMEOUT_DEFAULT = 40;
  localparam int WD_WIDTH        = 6;

endpackage

// File: rtl/multdiv_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  output logic grant_o,
  output logic grant_valid_o
);

  always_comb begin
    grant_valid_o = valid0_i | valid1_i;
    if (valid0_i && valid1_i) begin
      grant_o = ~last_grant_i;
    end else begin
      grant_o = valid1_i;
    end
  end

endmodule

// File: rtl/multdiv_arbiter.sv
// Shares one multdiv unit between two requesters, with a watchdog that aborts
// operations whose result never arrives.
module multdiv_arbiter
  import multdiv_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic        req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [4:0]  req0_tag,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic        req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req1_tag,
  output logic        req1_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_tag,
  output logic        resp_exception,
  output logic        resp_timeout,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        busy
);

  localparam logic [WD_WIDTH-1:0] TIMEOUT_CNT = WD_WIDTH'(TIMEOUT);

  state_e              state_q, state_d;
  logic                op_q, op_d;
  logic [31:0]         a_q, a_d;
  logic [31:0]         b_q, b_d;
  logic [4:0]          tag_q, tag_d;
  logic                id_q, id_d;
  logic                last_grant_q, last_grant_d;
  logic [WD_WIDTH-1:0] count_q, count_d;
  logic [31:0]         data_q, data_d;
  logic                exc_q, exc_d;
  logic                to_q, to_d;

  logic grant, grant_valid;

  rr_arb2 u_rr_arb2 (
    .valid0_i      (req0_valid),
    .valid1_i      (req1_valid),
    .last_grant_i  (last_grant_q),
    .grant_o       (grant),
    .grant_valid_o (grant_valid)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_MULT;
      a_q          <= '0;
      b_q          <= '0;
      tag_q        <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      count_q      <= '0;
      data_q       <= '0;
      exc_q        <= 1'b0;
      to_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      tag_q        <= tag_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      data_q       <= data_d;
      exc_q        <= exc_d;
      to_q         <= to_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    tag_d        = tag_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    count_d      = count_q;
    data_d       = data_q;
    exc_d        = exc_q;
    to_d         = to_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req0_ready = grant_valid & ~grant;
        req1_ready = grant_valid & grant;
        if (grant_valid) begin
          op_d    = grant ? req1_op  : req0_op;
          a_d     = grant ? req1_a   : req0_a;
          b_d     = grant ? req1_b   : req0_b;
          tag_d   = grant ? req1_tag : req0_tag;
          id_d    = grant;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        last_grant_d = id_q;
        count_d      = '0;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        count_d = count_q + 1'b1;
        // RDY seen in the first WAIT cycle may be left over from the previous op
        if ((count_q != '0) && md_resultRDY) begin
          data_d  = md_result;
          exc_d   = md_exception;
          to_d    = 1'b0;
          state_d = ST_RESP;
        end else if (count_q == TIMEOUT_CNT) begin
          data_d  = '0;
          exc_d   = 1'b1;
          to_d    = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign md_operandA    = a_q;
  assign md_operandB    = b_q;
  assign md_ctrl_MULT   = (state_q == ST_ISSUE) && (op_q == OP_MULT);
  assign md_ctrl_DIV    = (state_q == ST_ISSUE) && (op_q == OP_DIV);
  assign resp_valid     = (state_q == ST_RESP);
  assign resp_id        = id_q;
  assign resp_tag       = tag_q;
  assign resp_data      = data_q;
  assign resp_exception = exc_q;
  assign resp_timeout   = to_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_multdiv_arbiter.sv
// Self-checking bench for multdiv_arbiter: directed vector table, hand-written
// tie/reset sequences and randomized traffic against a behavioural multdiv stub.
module tb_multdiv_arbiter;
  import multdiv_arb_pkg::*;

  localparam int TO       = 40;
  localparam int STUB_LAT = 33;

  typedef struct {
    logic        v0;
    logic        v1;
    logic        op0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [4:0]  t0;
    logic        op1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [4:0]  t1;
    logic        noRdy;
    int          hold;
    logic        expId;
    logic [31:0] expData;
    logic [4:0]  expTag;
    logic        expExc;
    logic        expTo;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid = 1'b0, req0_op = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0;
  logic [4:0]  req0_tag = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0, req1_op = 1'b0;
  logic [31:0] req1_a = '0, req1_b = '0;
  logic [4:0]  req1_tag = '0;
  logic        req1_ready;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        resp_id;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic        resp_exception, resp_timeout;
  logic [31:0] md_operandA, md_operandB;
  logic        md_ctrl_MULT, md_ctrl_DIV;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0;
  logic        md_resultRDY = 1'b0;
  logic        busy;

  int   errors = 0;
  int   checks = 0;
  logic lastGrantModel = 1'b1;

  logic        stubNoRdy = 1'b0;
  logic        stubStartSeen = 1'b0;
  int          stubCnt = 0;
  logic        stubDiv = 1'b0;
  logic [31:0] stubA = '0, stubB = '0;

  vec_t vecs[8];

  always #5 clock = ~clock;

  multdiv_arbiter #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_tag(req0_tag), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_tag(req1_tag), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_tag(resp_tag), .resp_exception(resp_exception),
    .resp_timeout(resp_timeout),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
    .busy(busy)
  );

  // Behavioural multdiv unit: result after STUB_LAT cycles, RDY lingers one
  // cycle into the next operation so the arbiter's stale-RDY masking is exercised.
  always @(posedge clock) begin
    stubStartSeen <= md_ctrl_MULT | md_ctrl_DIV;
    if (md_ctrl_MULT | md_ctrl_DIV) begin
      stubCnt <= STUB_LAT;
      stubDiv <= md_ctrl_DIV;
      stubA   <= md_operandA;
      stubB   <= md_operandB;
    end else if (stubCnt > 0) begin
      stubCnt <= stubCnt - 1;
      if (stubCnt == 1 && !stubNoRdy) begin
        md_resultRDY <= 1'b1;
        if (!stubDiv) begin
          md_result    <= stubA * stubB;
          md_exception <= 1'b0;
        end else if (stubB == 32'd0) begin
          md_result    <= 32'hFFFF_FFFF;
          md_exception <= 1'b1;
        end else begin
          md_result    <= stubA / stubB;
          md_exception <= 1'b0;
        end
      end
    end
    if (stubStartSeen) md_resultRDY <= 1'b0;
  end

  function automatic logic [31:0] refResult(input logic op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    if (op == OP_MULT) begin
      prod = {32'd0, a} * {32'd0, b};
      return prod[31:0];
    end
    if (b == 32'd0) return 32'hFFFF_FFFF;
    return a / b;
  endfunction

  function automatic vec_t mkVec(input logic v0, input logic v1,
                                 input logic op0, input logic [31:0] a0, input logic [31:0] b0, input logic [4:0] t0,
                                 input logic op1, input logic [31:0] a1, input logic [31:0] b1, input logic [4:0] t1,
                                 input logic noRdy, input int hold, input logic expId,
                                 input logic [31:0] expData, input logic [4:0] expTag,
                                 input logic expExc, input logic expTo);
    vec_t v;
    v.v0 = v0; v.v1 = v1;
    v.op0 = op0; v.a0 = a0; v.b0 = b0; v.t0 = t0;
    v.op1 = op1; v.a1 = a1; v.b1 = b1; v.t1 = t1;
    v.noRdy = noRdy; v.hold = hold; v.expId = expId;
    v.expData = expData; v.expTag = expTag; v.expExc = expExc; v.expTo = expTo;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for resp_valid; returns the number of negedges observed.
  task automatic waitResp(input string nm, output int waits);
    waits = 0;
    while (waits < 200) begin
      @(negedge clock);
      #1;
      waits++;
      if (waits == 1) checkOutput({nm, " pulseOnce"}, {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
      if (resp_valid) break;
    end
    if (!resp_valid) checkOutput({nm, " respSeen"}, {31'd0, resp_valid}, 32'd1);
  endtask

  task automatic checkResp(input string nm, input logic id, input logic [31:0] data,
                           input logic [4:0] tag, input logic exc, input logic to);
    checkOutput({nm, " respFlags"}, {25'd0, resp_valid, resp_id, resp_exception, resp_timeout, 3'd0},
                {25'd0, 1'b1, id, exc, to, 3'd0});
    checkOutput({nm, " respData"}, resp_data, data);
    checkOutput({nm, " respTag"}, {27'd0, resp_tag}, {27'd0, tag});
  endtask

  task automatic releaseResp(input string nm);
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    #1;
    checkOutput({nm, " backToIdle"}, {30'd0, busy, resp_valid}, 32'd0);
  endtask

  task automatic applyStimulus(input vec_t v, input string nm);
    int          waits;
    logic        wOp;
    logic [31:0] wA, wB;
    @(negedge clock);
    stubNoRdy  = v.noRdy;
    req0_op = v.op0; req0_a = v.a0; req0_b = v.b0; req0_tag = v.t0; req0_valid = v.v0;
    req1_op = v.op1; req1_a = v.a1; req1_b = v.b1; req1_tag = v.t1; req1_valid = v.v1;
    #1;
    checkOutput({nm, " grant"}, {30'd0, req0_ready, req1_ready}, v.expId ? 32'd1 : 32'd2);
    if (!(req0_ready ^ req1_ready)) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      return;
    end
    wOp = v.expId ? v.op1 : v.op0;
    wA  = v.expId ? v.a1  : v.a0;
    wB  = v.expId ? v.b1  : v.b0;
    @(negedge clock);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    checkOutput({nm, " issue"}, {29'd0, md_ctrl_MULT, md_ctrl_DIV, busy},
                {29'd0, wOp == OP_MULT, wOp == OP_DIV, 1'b1});
    checkOutput({nm, " opA"}, md_operandA, wA);
    checkOutput({nm, " opB"}, md_operandB, wB);
    waitResp(nm, waits);
    if (v.noRdy) checkOutput({nm, " toWindow"}, {31'd0, (waits - 1 >= TO) && (waits - 1 <= TO + 1)}, 32'd1);
    checkResp(nm, v.expId, v.expData, v.expTag, v.expExc, v.expTo);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clock);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      checkOutput({nm, " holdCtl"},
                  {22'd0, req0_ready, req1_ready, resp_valid, resp_id, resp_tag, resp_exception, resp_timeout},
                  {22'd0, 1'b0, 1'b0, 1'b1, v.expId, v.expTag, v.expExc, v.expTo});
      checkOutput({nm, " holdData"}, resp_data, v.expData);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    releaseResp(nm);
    lastGrantModel = v.expId;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waits;
    int stray;

    vecs[0] = mkVec(1, 0, OP_MULT, 6, 7, 5,            OP_MULT, 0, 0, 0,      0, 0,  0, 32'd42,         5,  0, 0);
    vecs[1] = mkVec(0, 1, OP_MULT, 0, 0, 0,            OP_DIV,  5, 0, 12,     0, 0,  1, 32'hFFFF_FFFF,  12, 1, 0);
    vecs[2] = mkVec(1, 1, OP_DIV,  100, 7, 3,          OP_MULT, 3, 4, 9,      0, 0,  0, 32'd14,         3,  0, 0);
    vecs[3] = mkVec(1, 1, OP_MULT, 2, 3, 1,            OP_MULT, 3, 4, 9,      0, 0,  1, 32'd12,         9,  0, 0);
    vecs[4] = mkVec(1, 0, OP_MULT, 9, 9, 7,            OP_MULT, 0, 0, 0,      1, 0,  0, 32'd0,          7,  1, 1);
    vecs[5] = mkVec(0, 1, OP_MULT, 0, 0, 0,            OP_DIV,  1000, 10, 31, 0, 10, 1, 32'd100,        31, 0, 0);
    vecs[6] = mkVec(1, 0, OP_MULT, 32'h1_0000, 32'h1_0000, 17, OP_MULT, 0, 0, 0, 0, 0, 0, 32'd0,        17, 0, 0);
    vecs[7] = mkVec(1, 0, OP_DIV,  32'hFFFF_FFFF, 3, 2, OP_MULT, 0, 0, 0,     0, 1,  0, 32'h5555_5555,  2,  0, 0);

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    checkOutput("reset ctl", {24'd0, busy, resp_valid, md_ctrl_MULT, md_ctrl_DIV, resp_id,
                              resp_exception, resp_timeout, req0_ready | req1_ready}, 32'd0);
    checkOutput("reset data", resp_data, 32'd0);
    checkOutput("reset operands", md_operandA | md_operandB, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of WAIT discards the operation
    @(negedge clock);
    stubNoRdy = 1'b0;
    req0_op = OP_MULT; req0_a = 11; req0_b = 13; req0_tag = 4; req0_valid = 1'b1;
    #1;
    checkOutput("rstSeq grant", {30'd0, req0_ready, req1_ready}, 32'd2);
    @(negedge clock);
    req0_valid = 1'b0;
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    #1;
    checkOutput("rstSeq ctl", {25'd0, busy, resp_valid, md_ctrl_MULT, md_ctrl_DIV, resp_id,
                               resp_exception, resp_timeout}, 32'd0);
    checkOutput("rstSeq data", resp_data, 32'd0);
    checkOutput("rstSeq tag", {27'd0, resp_tag}, 32'd0);
    checkOutput("rstSeq opA", md_operandA, 32'd0);
    checkOutput("rstSeq opB", md_operandB, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    lastGrantModel = 1'b1;
    stray = 0;
    repeat (50) begin
      @(negedge clock);
      #1;
      if (resp_valid || busy) stray++;
    end
    checkOutput("rstSeq noResp", stray, 32'd0);

    // Tie sequence: req1 stays pending while req0 comes back with new work
    @(negedge clock);
    req0_op = OP_DIV;  req0_a = 100; req0_b = 7; req0_tag = 3; req0_valid = 1'b1;
    req1_op = OP_MULT; req1_a = 3;   req1_b = 4; req1_tag = 9; req1_valid = 1'b1;
    #1;
    checkOutput("tie1 grant", {30'd0, req0_ready, req1_ready}, 32'd2);
    @(negedge clock);
    req0_valid = 1'b0;
    #1;
    checkOutput("tie1 issue", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd1);
    waitResp("tie1", waits);
    checkResp("tie1", 1'b0, 32'd14, 5'd3, 1'b0, 1'b0);
    req0_op = OP_MULT; req0_a = 2; req0_b = 5; req0_tag = 2; req0_valid = 1'b1;
    releaseResp("tie1");
    checkOutput("tie2 grant", {30'd0, req0_ready, req1_ready}, 32'd1);
    @(negedge clock);
    req1_valid = 1'b0;
    #1;
    checkOutput("tie2 issue", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd2);
    waitResp("tie2", waits);
    checkResp("tie2", 1'b1, 32'd12, 5'd9, 1'b0, 1'b0);
    releaseResp("tie2");
    checkOutput("tie3 grant", {30'd0, req0_ready, req1_ready}, 32'd2);
    @(negedge clock);
    req0_valid = 1'b0;
    waitResp("tie3", waits);
    checkResp("tie3", 1'b0, 32'd10, 5'd2, 1'b0, 1'b0);
    releaseResp("tie3");
    lastGrantModel = 1'b0;

    // Randomized traffic against the reference model
    for (int it = 0; it < 30; it++) begin
      vec_t        r;
      logic        wOp;
      logic [31:0] wA, wB;
      r.v0  = 1'($urandom_range(0, 1));
      r.v1  = 1'($urandom_range(0, 1));
      if (!r.v0 && !r.v1) r.v0 = 1'b1;
      r.op0 = 1'($urandom_range(0, 1));
      r.a0  = $urandom;
      r.b0  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 5000));
      r.t0  = 5'($urandom_range(0, 31));
      r.op1 = 1'($urandom_range(0, 1));
      r.a1  = $urandom;
      r.b1  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 5000));
      r.t1  = 5'($urandom_range(0, 31));
      r.noRdy = ($urandom_range(0, 9) == 0);
      r.hold  = int'($urandom_range(0, 3));
      r.expId = (r.v0 && r.v1) ? ~lastGrantModel : r.v1;
      wOp = r.expId ? r.op1 : r.op0;
      wA  = r.expId ? r.a1  : r.a0;
      wB  = r.expId ? r.b1  : r.b0;
      r.expTag = r.expId ? r.t1 : r.t0;
      if (r.noRdy) begin
        r.expData = 32'd0;
        r.expExc  = 1'b1;
        r.expTo   = 1'b1;
      end else begin
        r.expData = refResult(wOp, wA, wB);
        r.expExc  = (wOp == OP_DIV) && (wB == 32'd0);
        r.expTo   = 1'b0;
      end
      applyStimulus(r, $sformatf("rand%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
